// File: rtl/counter_event_fifo_if.sv
// Event stream between the counter event FIFO and its environment.
//   sample_en / din : counter samples into the block
//   ev_valid / ev_data / ev_ready : valid/ready event output stream,
//                                   ev_data = {type[1:0], value[3:0]}
// master : the FIFO block itself (consumes samples, sources events)
// slave  : the environment (drives samples, sinks events)
interface counter_event_fifo_if;
  logic       sample_en;
  logic [3:0] din;
  logic       ev_valid;
  logic       ev_ready;
  logic [5:0] ev_data;

  modport master (
    input  sample_en, din, ev_ready,
    output ev_valid, ev_data
  );

  modport slave (
    output sample_en, din, ev_ready,
    input  ev_valid, ev_data
  );
endinterface

// File: rtl/counter_event_fifo.sv
// Watches samples of a 4-bit up/down counter, classifies each sample-to-
// sample transition and queues the interesting ones in a small event FIFO.
// Also keeps saturating counts of wrap-ups, wrap-downs and dropped events.
//
// Ports:
//   clk        : sole clock, rising edge
//   rst        : synchronous active-high reset
//   bus        : counter_event_fifo_if.master (samples in, event stream out)
//   level      : FIFO occupancy 0..DEPTH
//   up_wraps   : saturating count of 15->0 transitions
//   down_wraps : saturating count of 0->15 transitions
//   drop_cnt   : saturating count of events lost to a full FIFO
//
// Event types: 01 wrap-up, 10 wrap-down, 11 step error (jump other than
// -1/0/+1 mod 16 that is not a wrap).
module counter_event_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  counter_event_fifo_if.master     bus,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         up_wraps,
  output logic [CNT_W-1:0]         down_wraps,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {
    EV_NONE    = 2'b00,
    EV_WRAP_UP = 2'b01,
    EV_WRAP_DN = 2'b10,
    EV_STEP    = 2'b11
  } ev_type_e;

  typedef struct packed {
    ev_type_e   typ;
    logic [3:0] val;
  } ev_t;

  // sample history
  logic [3:0] prev;
  logic       prev_valid;

  // FIFO storage; contents are don't-care outside [rptr, rptr+level)
  ev_t           mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  ev_type_e   cls;
  logic [3:0] diff;
  logic       fire, empty, full, push, pop, drop;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Wrap checks come first: 15->0 is a +1 step numerically but still an event.
  always_comb begin
    diff = bus.din - prev;
    cls  = EV_NONE;
    if (prev == 4'hF && bus.din == 4'h0)
      cls = EV_WRAP_UP;
    else if (prev == 4'h0 && bus.din == 4'hF)
      cls = EV_WRAP_DN;
    else if (diff != 4'h0 && diff != 4'h1 && diff != 4'hF)
      cls = EV_STEP;
  end

  assign fire  = bus.sample_en & prev_valid & (cls != EV_NONE);
  assign empty = (level == '0);
  assign full  = (level == FULL_LVL);
  assign pop   = ~empty & bus.ev_ready;
  // A same-cycle pop frees the head slot, so a full FIFO can still accept.
  assign push  = fire & (~full | pop);
  assign drop  = fire & full & ~pop;

  assign bus.ev_valid = ~empty;
  assign bus.ev_data  = empty ? 6'd0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      prev_valid <= 1'b0;
      wptr       <= '0;
      rptr       <= '0;
      level      <= '0;
      up_wraps   <= '0;
      down_wraps <= '0;
      drop_cnt   <= '0;
    end else begin
      if (bus.sample_en) begin
        prev       <= bus.din;
        prev_valid <= 1'b1;
      end
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      // Wrap stats count detections, including ones that end up dropped.
      if (fire && cls == EV_WRAP_UP) up_wraps   <= sat_inc(up_wraps);
      if (fire && cls == EV_WRAP_DN) down_wraps <= sat_inc(down_wraps);
      if (drop)                      drop_cnt   <= sat_inc(drop_cnt);
    end
  end

  // Storage has no reset; occupancy tracking alone defines what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wptr] <= ev_t'{typ: cls, val: bus.din};
  end

endmodule

// File: tb/tb_counter_event_fifo.sv
module tb_counter_event_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1;
  counter_event_fifo_if bus0 ();
  counter_event_fifo_if bus1 ();

  logic [3:0] level0, level1;
  logic [7:0] up0, dn0, drp0;
  logic [1:0] up1, dn1, drp1;

  counter_event_fifo #(.DEPTH(8), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst0), .bus(bus0.master), .level(level0),
    .up_wraps(up0), .down_wraps(dn0), .drop_cnt(drp0)
  );

  counter_event_fifo #(.DEPTH(8), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst1), .bus(bus1.master), .level(level1),
    .up_wraps(up1), .down_wraps(dn1), .drop_cnt(drp1)
  );

  typedef struct {
    logic       rst;
    logic       se;
    logic [3:0] din;
    logic       rdy;
    logic       v;
    logic [5:0] d;
    logic [3:0] lvl;
    logic [7:0] up;
    logic [7:0] dn;
    logic [7:0] drp;
  } vec_t;

  vec_t vecs[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic vec_t mk(logic r, logic s, logic [3:0] di, logic y,
                              logic v, logic [5:0] d, logic [3:0] l,
                              logic [7:0] u, logic [7:0] dn, logic [7:0] dr);
    vec_t t;
    t.rst = r; t.se = s; t.din = di; t.rdy = y;
    t.v = v; t.d = d; t.lvl = l; t.up = u; t.dn = dn; t.drp = dr;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick0(input logic r, input logic s, input logic [3:0] d, input logic y);
    @(negedge clk);
    rst0 = r; bus0.sample_en = s; bus0.din = d; bus0.ev_ready = y;
    @(posedge clk);
    #1;
  endtask

  task automatic tick1(input logic r, input logic s, input logic [3:0] d);
    @(negedge clk);
    rst1 = r; bus1.sample_en = s; bus1.din = d; bus1.ev_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] ovf_vals [10] = '{4'd3, 4'd6, 4'd9, 4'd12, 4'd15, 4'd2, 4'd5, 4'd8, 4'd11, 4'd14};
  logic [3:0] drain_vals [8] = '{4'd6, 4'd9, 4'd12, 4'd15, 4'd2, 4'd5, 4'd8, 4'd1};

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    bus0.sample_en = 1'b0; bus0.din = 4'd0; bus0.ev_ready = 1'b0;
    bus1.sample_en = 1'b0; bus1.din = 4'd0; bus1.ev_ready = 1'b0;

    // {rst, se, din, rdy} -> {valid, data, level, up, down, drop}
    // up-count wrap
    vecs.push_back(mk(1, 0,  0, 0, 0, 6'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 13, 0, 0, 6'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 14, 0, 0, 6'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 15, 0, 0, 6'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,  0, 0, 1, 6'h10, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1,  1, 0, 1, 6'h10, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0,  1, 1, 0, 6'h00, 0, 1, 0, 0));
    // down-count wrap, then hold 14
    vecs.push_back(mk(0, 1,  2, 0, 0, 6'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1,  1, 0, 0, 6'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1,  0, 0, 0, 6'h00, 0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 15, 0, 1, 6'h2F, 1, 1, 1, 0));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0, 1, 14, 0, 1, 6'h2F, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 14, 1, 0, 6'h00, 0, 1, 1, 0));
    // step error, with a sample_en gap that must not update prev
    vecs.push_back(mk(1, 0,  0, 0, 0, 6'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,  4, 0, 0, 6'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  9, 0, 0, 6'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,  5, 0, 0, 6'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,  4, 0, 0, 6'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,  7, 0, 1, 6'h37, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  7, 0, 1, 6'h37, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0,  7, 1, 0, 6'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0,  7, 1, 0, 6'h00, 0, 0, 0, 0));
    // reset mid-operation at level 3; 9 -> 0 across reset is not an error
    vecs.push_back(mk(0, 1,  0, 0, 1, 6'h30, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1,  7, 0, 1, 6'h30, 2, 0, 0, 0));
    vecs.push_back(mk(0, 1,  9, 0, 1, 6'h30, 3, 0, 0, 0));
    vecs.push_back(mk(1, 1,  3, 1, 0, 6'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,  0, 0, 0, 6'h00, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1,  1, 0, 0, 6'h00, 0, 0, 0, 0));

    foreach (vecs[i]) begin
      tick0(vecs[i].rst, vecs[i].se, vecs[i].din, vecs[i].rdy);
      if (i == 0) begin
        rst1 = 1'b0;
        chk("dut1_reset", {bus1.ev_valid, bus1.ev_data, level1, up1, dn1, drp1},
            {1'b0, 6'h00, 4'd0, 2'd0, 2'd0, 2'd0});
      end
      chk($sformatf("vec%0d", i),
          {bus0.ev_valid, bus0.ev_data, level0, up0, dn0, drp0},
          {vecs[i].v, vecs[i].d, vecs[i].lvl, vecs[i].up, vecs[i].dn, vecs[i].drp});
    end

    // overflow: 10 step errors into a depth-8 FIFO
    tick0(1, 0, 0, 0);
    tick0(0, 1, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick0(0, 1, ovf_vals[i], 0);
      chk($sformatf("ovf_lvl%0d", i), {level0, drp0},
          {4'((i < 8) ? i + 1 : 8), 8'((i < 8) ? 0 : i - 7)});
    end
    chk("ovf_head", bus0.ev_data, 6'h33);
    // push + pop at full: level holds, no new drop, head advances
    tick0(0, 1, 1, 1);
    chk("full_pushpop", {level0, drp0, bus0.ev_data}, {4'd8, 8'd2, 6'h36});
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), {bus0.ev_valid, bus0.ev_data}, {1'b1, 2'b11, drain_vals[i]});
      tick0(0, 0, 0, 1);
    end
    chk("drained", {bus0.ev_valid, bus0.ev_data, level0, drp0}, {1'b0, 6'h00, 4'd0, 8'd2});

    // saturation on CNT_W=2: 5 wrap-ups, 4 wrap-downs, 9 events -> 1 drop
    tick1(0, 1, 15);
    for (int i = 0; i < 9; i++) begin
      tick1(0, 1, (i % 2 == 0) ? 4'd0 : 4'd15);
      if (i == 4)
        chk("sat_up3", {up1, dn1}, {2'd3, 2'd2});
    end
    chk("sat_final", {up1, dn1, drp1, level1}, {2'd3, 2'd3, 2'd1, 4'd8});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
